// File: rtl/calc_controller_if.sv
//------------------------------------------------------------------------------
// Module      : calc_controller_if
// Description : Bus bundle between the calc_controller sequencer and its
//               environment (SRAM port, result buffer, adder operands, control).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface calc_controller_if #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64
);
    // control and address window
    logic                     start_i;
    logic [ADDR_W-1:0]        rd_start_addr_i;
    logic [ADDR_W-1:0]        rd_end_addr_i;
    logic [ADDR_W-1:0]        wr_start_addr_i;
    logic [ADDR_W-1:0]        wr_end_addr_i;

    // data returning to the sequencer
    logic [MEM_WORD_SIZE-1:0] mem_rdata_i;
    logic [MEM_WORD_SIZE-1:0] buffer_i;

    // SRAM port
    logic                     mem_rd_en_o;
    logic                     mem_wr_en_o;
    logic [ADDR_W-1:0]        mem_addr_o;
    logic [MEM_WORD_SIZE-1:0] mem_wdata_o;

    // adder / buffer steering
    logic [DATA_W-1:0]        op_a_o;
    logic [DATA_W-1:0]        op_b_o;
    logic                     loc_sel_o;

    // status
    logic                     busy_o;
    logic                     done_o;
    logic                     overflow_o;

    // sequencer side
    modport slave (
        input  start_i, rd_start_addr_i, rd_end_addr_i, wr_start_addr_i,
               wr_end_addr_i, mem_rdata_i, buffer_i,
        output mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o,
               op_a_o, op_b_o, loc_sel_o, busy_o, done_o, overflow_o
    );

    // environment side (SRAM, buffer, host)
    modport master (
        output start_i, rd_start_addr_i, rd_end_addr_i, wr_start_addr_i,
               wr_end_addr_i, mem_rdata_i, buffer_i,
        input  mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o,
               op_a_o, op_b_o, loc_sel_o, busy_o, done_o, overflow_o
    );
endinterface

`default_nettype wire

// File: rtl/calc_controller.sv
//------------------------------------------------------------------------------
// Module      : calc_controller
// Description : Reads {B,A} operand words from SRAM, feeds A/B to the adder,
//               steers the result buffer half via loc_sel so two sums pack
//               into one 64-bit word, and writes packed words back to SRAM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module calc_controller #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    calc_controller_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_ADD   = 3'd3,
        S_PAD   = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]   rd_end;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   wr_end;
    logic                half;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic                loc_sel;
    logic                overflow;

    logic                rd_last;
    logic                wr_legal;

    assign rd_last  = (rd_ptr == rd_end);
    assign wr_legal = (wr_ptr <= wr_end);

    // State register; reset aborts any operation immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_nxt        = state;
        bus.mem_rd_en_o  = 1'b0;
        bus.mem_wr_en_o  = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_wdata_o  = '0;
        bus.busy_o       = 1'b1;
        bus.done_o       = 1'b0;
        case (state)
            S_IDLE: begin
                bus.busy_o = 1'b0;
                if (bus.start_i) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                bus.mem_rd_en_o = 1'b1;
                bus.mem_addr_o  = rd_ptr;
                state_nxt       = S_WAIT;
            end
            S_WAIT: begin
                state_nxt = S_ADD;
            end
            S_ADD: begin
                if (half) begin
                    state_nxt = S_WRITE;
                end else if (rd_last) begin
                    state_nxt = S_PAD;
                end else begin
                    state_nxt = S_READ;
                end
            end
            S_PAD: begin
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                // Out-of-window writes are dropped; overflow records it.
                bus.mem_wr_en_o = wr_legal;
                bus.mem_addr_o  = wr_ptr;
                bus.mem_wdata_o = bus.buffer_i;
                state_nxt       = rd_last ? S_DONE : S_READ;
            end
            S_DONE: begin
                bus.done_o = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Pointers, operand registers, buffer half select and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr   <= '0;
            rd_end   <= '0;
            wr_ptr   <= '0;
            wr_end   <= '0;
            half     <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            loc_sel  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        rd_ptr   <= bus.rd_start_addr_i;
                        rd_end   <= bus.rd_end_addr_i;
                        wr_ptr   <= bus.wr_start_addr_i;
                        wr_end   <= bus.wr_end_addr_i;
                        half     <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // Read data is valid now; present it to the adder in ADD.
                    op_a    <= bus.mem_rdata_i[DATA_W-1:0];
                    op_b    <= bus.mem_rdata_i[MEM_WORD_SIZE-1:DATA_W];
                    loc_sel <= half;
                end
                S_ADD: begin
                    if (!half) begin
                        if (rd_last) begin
                            // Odd word count: zero sum goes into the high half.
                            op_a    <= '0;
                            op_b    <= '0;
                            loc_sel <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                            half   <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (!wr_legal) begin
                        overflow <= 1'b1;
                    end
                    wr_ptr <= wr_ptr + 1'b1;
                    half   <= 1'b0;
                    if (!rd_last) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.op_a_o     = op_a;
    assign bus.op_b_o     = op_b;
    assign bus.loc_sel_o  = loc_sel;
    assign bus.overflow_o = overflow;

endmodule

`default_nettype wire
